// File: rtl/synth_pkg.sv
// Shared definitions for the tone synthesiser.
//   VOICES         number of oscillator voices
//   tone_code_t    4-bit tone code, 0 = rest, 1..15 = chromatic note from C4
//   HALF_PERIOD    half-period table in 50 MHz clock cycles, entry 0 unused
//   shifted_half() half-period after the simulation speed-up shift, never below 1
package synth_pkg;

  localparam int VOICES = 4;

  typedef logic [3:0] tone_code_t;

  localparam int HALF_PERIOD [0:15] = '{
    0,     95556, 90193, 85131, 80353, 75843, 71587, 67568,
    63776, 60197, 56818, 53629, 50619, 47778, 45097, 42566
  };

  function automatic int shifted_half(input tone_code_t code, input int shift);
    int v;
    v = HALF_PERIOD[code] >> shift;
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/tone_osc.sv
// One square-wave voice.
//   clk_i, reset_i  clock, synchronous active-high reset
//   load_i          sample code_i this cycle
//   code_i          new tone code
//   sq_o            square output
//   active_o        latched code is nonzero
//   amp_o           current amplitude of this voice
// With TONE_SYNTH_DECAY_EN defined the amplitude restarts at VOICE_AMP on every
// nonzero load and then steps down by one every BEAT_TICKS/16 cycles, floor 4.
module tone_osc
  import synth_pkg::*;
#(
  parameter int DIV_WIDTH    = 17,
  parameter int PERIOD_SHIFT = 0,
  parameter int VOICE_AMP    = 15
`ifdef TONE_SYNTH_DECAY_EN
  , parameter int BEAT_TICKS = 6_250_000
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  tone_code_t code_i,
  output logic       sq_o,
  output logic       active_o,
  output logic [3:0] amp_o
);

  tone_code_t           code_q, code_d;
  logic [DIV_WIDTH-1:0] ph_q, ph_d;
  logic                 sq_q, sq_d;
  logic [DIV_WIDTH-1:0] hp_m1;
  logic                 run;

  always_comb begin
    hp_m1 = DIV_WIDTH'(shifted_half(code_q, PERIOD_SHIFT) - 1);
  end

  always_comb begin
    code_d = code_q;
    ph_d   = ph_q;
    sq_d   = sq_q;
    run    = 1'b0;
    if (load_i) begin
      code_d = code_i;
      // A rest or a different note re-strikes from phase 0; the same note
      // keeps running so held notes do not glitch at the beat boundary.
      if (code_i == 4'd0 || code_i != code_q) begin
        ph_d = '0;
        sq_d = 1'b0;
      end else begin
        run = 1'b1;
      end
    end else if (code_q != 4'd0) begin
      run = 1'b1;
    end
    if (run) begin
      if (ph_q == hp_m1) begin
        ph_d = '0;
        sq_d = ~sq_q;
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      code_q <= '0;
      ph_q   <= '0;
      sq_q   <= 1'b0;
    end else begin
      code_q <= code_d;
      ph_q   <= ph_d;
      sq_q   <= sq_d;
    end
  end

  assign sq_o     = sq_q;
  assign active_o = (code_q != 4'd0);

`ifdef TONE_SYNTH_DECAY_EN
  localparam int DECAY_TICKS = (BEAT_TICKS / 16 < 1) ? 1 : BEAT_TICKS / 16;
  localparam int DCW         = $clog2(DECAY_TICKS + 1);

  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [3:0]     amp_q, amp_d;

  always_comb begin
    dcnt_d = dcnt_q;
    amp_d  = amp_q;
    if (load_i && code_i != 4'd0) begin
      dcnt_d = '0;
      amp_d  = 4'(VOICE_AMP);
    end else if (dcnt_q == DCW'(DECAY_TICKS - 1)) begin
      dcnt_d = '0;
      if (amp_q > 4'd4) amp_d = amp_q - 4'd1;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dcnt_q <= '0;
      amp_q  <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      amp_q  <= amp_d;
    end
  end

  assign amp_o = amp_q;
`else
  assign amp_o = 4'(VOICE_AMP);
`endif

endmodule

// File: rtl/tone_synth.sv
// Playback end of the song sequencer: paces the sequencer with beat_tick,
// latches four tone codes each beat, runs four square-wave voices, mixes them
// into a 6-bit sample and drives a PWM audio pin.
//   clk, reset     clock, synchronous active-high reset
//   enable         1 = beat counter runs, 0 = counter holds
//   tone0..tone3   tone codes from the sequencer, 0 = rest
//   beat_tick      one-cycle step pulse to the sequencer
//   voice_active   bit v set while voice v holds a nonzero code
//   sample         registered mix, 0..4*VOICE_AMP
//   audio_pwm      PWM of sample over a 63-cycle period
// Optional feature macro: TONE_SYNTH_DECAY_EN (per-voice amplitude decay).
module tone_synth
  import synth_pkg::*;
#(
  parameter int BEAT_TICKS   = 6_250_000,
  parameter int DIV_WIDTH    = 17,
  parameter int PERIOD_SHIFT = 0,
  parameter int VOICE_AMP    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] tone0,
  input  logic [3:0] tone1,
  input  logic [3:0] tone2,
  input  logic [3:0] tone3,
  output logic       beat_tick,
  output logic [3:0] voice_active,
  output logic [5:0] sample,
  output logic       audio_pwm
);

  localparam int CW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q;
  logic [5:0]    sample_q, sample_d;
  logic [5:0]    pwm_cnt_q, pwm_cnt_d;
  logic          pwm_q;

  tone_code_t          tones [VOICES];
  logic [VOICES-1:0]   sq;
  logic [3:0]          amp [VOICES];

  assign tones[0] = tone0;
  assign tones[1] = tone1;
  assign tones[2] = tone2;
  assign tones[3] = tone3;

  assign beat_tick = enable && (cnt_q == CW'(BEAT_TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = beat_tick ? '0 : cnt_q + 1'b1;
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    tone_osc #(
      .DIV_WIDTH   (DIV_WIDTH),
      .PERIOD_SHIFT(PERIOD_SHIFT),
      .VOICE_AMP   (VOICE_AMP)
`ifdef TONE_SYNTH_DECAY_EN
      , .BEAT_TICKS(BEAT_TICKS)
`endif
    ) u_osc (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (load_q),
      .code_i  (tones[v]),
      .sq_o    (sq[v]),
      .active_o(voice_active[v]),
      .amp_o   (amp[v])
    );
  end

  // Four voices of at most 15 each sum to at most 60, so 6 bits never wrap.
  always_comb begin
    sample_d = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (sq[v]) sample_d = sample_d + {2'b00, amp[v]};
    end
  end

  assign pwm_cnt_d = (pwm_cnt_q == 6'd62) ? '0 : pwm_cnt_q + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      load_q    <= 1'b1;  // forces a tone load on the first cycle out of reset
      sample_q  <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      load_q    <= beat_tick;
      sample_q  <= sample_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= (pwm_cnt_q < sample_q);
    end
  end

  assign sample    = sample_q;
  assign audio_pwm = pwm_q;

endmodule

// File: tb/tb_tone_synth.sv
module tb_tone_synth;

  localparam int BT  = 1000;
  localparam int SH  = 8;
  localparam int AMP = 15;

  // Half periods in 50 MHz cycles, C4 upward in semitones; entry 0 unused.
  localparam int HP_RAW [16] = '{
    0,     95556, 90193, 85131, 80353, 75843, 71587, 67568,
    63776, 60197, 56818, 53629, 50619, 47778, 45097, 42566
  };

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] tn [4];
  logic       beat_tick, audio_pwm;
  logic [3:0] voice_active;
  logic [5:0] sample;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index since reset, beat counter, and per voice the
  // current code plus the cycle at which its square wave started from phase 0.
  int m_n, m_cnt;
  bit m_load;
  int m_code [4];
  int m_start [4];
  int m_astart [4];
  int e_sample;
  bit e_pwm;

  tone_synth #(
    .BEAT_TICKS  (BT),
    .DIV_WIDTH   (17),
    .PERIOD_SHIFT(SH),
    .VOICE_AMP   (AMP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tone0       (tn[0]),
    .tone1       (tn[1]),
    .tone2       (tn[2]),
    .tone3       (tn[3]),
    .beat_tick   (beat_tick),
    .voice_active(voice_active),
    .sample      (sample),
    .audio_pwm   (audio_pwm)
  );

  always #5 clk = ~clk;

  function automatic int hp(input int c);
    int v;
    v = HP_RAW[c] >> SH;
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int amp_at(input int v, input int n);
`ifdef TONE_SYNTH_DECAY_EN
    int a;
    a = AMP - (n - m_astart[v]) / (BT / 16);
    return (a < 4) ? 4 : a;
`else
    return AMP + 0 * (v + n);
`endif
  endfunction

  function automatic bit sq_at(input int v, input int n);
    if (m_code[v] == 0 || n < m_start[v]) return 1'b0;
    return ((n - m_start[v]) / hp(m_code[v])) % 2 == 1;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] va;
    for (int v = 0; v < 4; v++) va[v] = (m_code[v] != 0);
    return {(enable && m_cnt == BT - 1), va, e_sample[5:0], e_pwm};
  endfunction

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic step();
    int  s;
    bit  tick;
    @(posedge clk);
    if (reset) begin
      m_n = 0; m_cnt = 0; m_load = 1'b1; e_sample = 0; e_pwm = 1'b0;
      for (int v = 0; v < 4; v++) begin m_code[v] = 0; m_start[v] = 0; m_astart[v] = 0; end
    end else begin
      tick = enable && (m_cnt == BT - 1);
      s = 0;
      for (int v = 0; v < 4; v++) if (sq_at(v, m_n)) s += amp_at(v, m_n);
      e_pwm    = (m_n % 63) < e_sample;
      e_sample = s;
      if (m_load) begin
        for (int v = 0; v < 4; v++) begin
          if (tn[v] == 4'd0) m_code[v] = 0;
          else begin
            if (int'(tn[v]) != m_code[v]) begin m_code[v] = tn[v]; m_start[v] = m_n + 1; end
            m_astart[v] = m_n + 1;
          end
        end
      end
      if (enable) m_cnt = tick ? 0 : m_cnt + 1;
      m_load = tick;
      m_n++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    for (int v = 0; v < 4; v++) tn[v] = 4'($urandom_range(1, 15));
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== 12'h000) begin
        errors++;
        $display("FAIL reset_state got=%h required=000", {beat_tick, voice_active, sample, audio_pwm});
      end
    end
    for (int v = 0; v < 4; v++) tn[v] = 4'd0;
    reset = 1'b0;
  endtask

  task automatic test_beat();
    int ticks = 0;
    for (int i = 0; i < 2100; i++) begin
      step();
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
        errors++;
        $display("FAIL model_beat cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
      end
      if (beat_tick) begin
        ticks++;
        checks++;
        if (m_n % 1000 != 999) begin
          errors++;
          $display("FAIL beat_position cyc=%0d required=999 mod 1000", m_n);
        end
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL beat_count got=%0d required=2", ticks);
    end
  endtask

  task automatic test_chord();
    int  waited = 0;
    int  high = 0;
    bit  found = 1'b0;
    for (int v = 0; v < 4; v++) tn[v] = 4'd1;
    while (!found && waited < 3000) begin
      step();
      waited++;
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
        errors++;
        $display("FAIL model_chord cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
      end
      if (sample != 6'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL chord_timeout sample stayed 0 for %0d cycles", waited);
    end
`ifndef TONE_SYNTH_DECAY_EN
    checks++;
    if (sample !== 6'd60) begin
      errors++;
      $display("FAIL chord_peak got=%0d required=60", sample);
    end
    for (int i = 0; i < 63; i++) begin
      step();
      if (audio_pwm) high++;
    end
    checks++;
    if (high != 60) begin
      errors++;
      $display("FAIL chord_pwm_duty got=%0d required=60 of 63", high);
    end
`endif
  endtask

  task automatic test_single_voice();
    int last = -1;
    int nchg = 0;
    logic [5:0] prev;
    tn[0] = 4'd10; tn[1] = 4'd0; tn[2] = 4'd0; tn[3] = 4'd0;
    prev = sample;
    for (int i = 0; i < 2600; i++) begin
      step();
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
        errors++;
        $display("FAIL model_single cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
      end
      if (sample != prev && voice_active == 4'b0001) begin
        nchg++;
        if (nchg >= 3) begin
          checks++;
          if (m_n - last != 221) begin
            errors++;
            $display("FAIL single_toggle_spacing got=%0d required=221", m_n - last);
          end
        end
        last = m_n;
      end
      prev = sample;
    end
    checks++;
    if (voice_active !== 4'b0001) begin
      errors++;
      $display("FAIL single_active got=%b required=0001", voice_active);
    end
  endtask

  task automatic test_legato_restrike();
    int b = -1;
    int rise = -1;
    int k = 0;
    tn[0] = 4'd1;
    while (b < 0 && k < 1100) begin
      step(); k++;
      if (beat_tick) b = m_n;
    end
    checks++;
    if (b < 0) begin
      errors++;
      $display("FAIL restrike_no_beat within %0d cycles", k);
    end else begin
      for (int i = 0; i < 600 && rise < 0; i++) begin
        step();
        checks++;
        if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
          errors++;
          $display("FAIL model_restrike cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
        end
        if (m_n == b + 3) begin
          checks++;
          if (sample !== 6'd0) begin
            errors++;
            $display("FAIL restrike_zero got=%0d required=0", sample);
          end
        end
        if (m_n > b + 3 && sample != 6'd0) rise = m_n;
      end
      checks++;
      if (rise - b != 376) begin
        errors++;
        $display("FAIL restrike_first_toggle got=%0d required=376 after beat", rise - b);
      end
    end
  endtask

  task automatic test_enable_hold();
    int b = -1;
    int k = 0;
    int p;
    int en_cnt = 0;
    int held_ticks = 0;
    bit done = 1'b0;
    while (b < 0 && k < 1100) begin
      step(); k++;
      if (beat_tick) b = m_n;
    end
    p = $urandom_range(100, 400);
    for (int j = 1; j <= 2000 && !done; j++) begin
      step();
      enable = (j < p || j >= p + 500);
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
        errors++;
        $display("FAIL model_enable cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
      end
      if (enable) en_cnt++;
      else if (beat_tick) held_ticks++;
      if (beat_tick) done = 1'b1;
    end
    enable = 1'b1;
    checks++;
    if (held_ticks != 0) begin
      errors++;
      $display("FAIL enable_hold_tick got=%0d required=0", held_ticks);
    end
    checks++;
    if (!done || en_cnt != 1000) begin
      errors++;
      $display("FAIL enable_resume got=%0d enabled cycles required=1000", en_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic [3:0] va;
    for (int v = 0; v < 4; v++) tn[v] = 4'($urandom_range(1, 15));
    while (sample == 6'd0 && k < 3000) begin step(); k++; end
    checks++;
    if (sample == 6'd0) begin
      errors++;
      $display("FAIL reset_mid_setup sample stayed 0 for %0d cycles", k);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({voice_active, sample, audio_pwm} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid_silence got=%h required=000", {voice_active, sample, audio_pwm});
    end
    reset = 1'b0;
    tn[2] = 4'd0;
    step();
    for (int v = 0; v < 4; v++) va[v] = (tn[v] != 4'd0);
    checks++;
    if (voice_active !== va) begin
      errors++;
      $display("FAIL reset_reload got=%b required=%b", voice_active, va);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step();
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
        errors++;
        $display("FAIL model_random cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
      end
      if ($urandom_range(0, 299) == 0) tn[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
    enable = 1'b1;
  endtask

`ifdef TONE_SYNTH_DECAY_EN
  task automatic test_decay();
    int mn = 99;
    reset = 1'b1; step(); reset = 1'b0;
    tn[0] = 4'd10; tn[1] = 4'd0; tn[2] = 4'd0; tn[3] = 4'd0;
    for (int i = 0; i < 999; i++) begin
      step();
      checks++;
      if ({beat_tick, voice_active, sample, audio_pwm} !== exp_vec()) begin
        errors++;
        $display("FAIL model_decay cyc=%0d got=%h required=%h", m_n, {beat_tick, voice_active, sample, audio_pwm}, exp_vec());
      end
      if (sample != 6'd0 && int'(sample) < mn) mn = sample;
    end
    checks++;
    if (mn != 4) begin
      errors++;
      $display("FAIL decay_floor got=%0d required=4", mn);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b1;
    for (int v = 0; v < 4; v++) tn[v] = 4'd0;
    test_reset();
    test_beat();
    test_chord();
    test_single_voice();
    test_legato_restrike();
    test_enable_hold();
    test_reset_mid();
    test_random();
`ifdef TONE_SYNTH_DECAY_EN
    test_decay();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
